// File: rtl/kernel_stage0_pkg.sv
// Shared widths, iteration count, saturation value and FSM encoding for the
// 19-by-5 bit sequential unsigned divider.
package kernel_stage0_pkg;
  localparam int DIVIDEND_W = 19;
  localparam int DIVISOR_W  = 5;
  localparam int QUOTIENT_W = 14;
  localparam int PREM_W     = DIVISOR_W + 1;
  localparam int ITERS      = 19;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(ITERS - 1);
  localparam logic [QUOTIENT_W-1:0] SAT_QUO   = 14'h3FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/kernel_stage0_udiv_19ns_5ns_14_seq_core.sv
// Restoring-division datapath: dividend/quotient shift register, partial
// remainder and the single-bit compare/subtract step.
module kernel_stage0_udiv_19ns_5ns_14_seq_core
  import kernel_stage0_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quo_next,
  output logic [DIVISOR_W-1:0]  rem_next,
  output logic [DIVISOR_W-1:0]  low_bits,
  output logic                  divisor_zero
);
  logic [DIVIDEND_W-1:0] quo_reg;
  logic [DIVISOR_W-1:0]  rem_reg;
  logic [DIVISOR_W-1:0]  div_reg;
  logic [PREM_W-1:0]     shifted;
  logic [DIVISOR_W-1:0]  diff;
  logic                  fits;

  // Remainder stays below the divisor, so only the shifted value needs the
  // extra bit; the difference is known to fit in DIVISOR_W bits when taken.
  always_comb begin
    shifted  = {rem_reg, quo_reg[DIVIDEND_W-1]};
    fits     = (shifted >= {1'b0, div_reg});
    diff     = shifted[DIVISOR_W-1:0] - div_reg;
    rem_next = fits ? diff : shifted[DIVISOR_W-1:0];
    quo_next = {quo_reg[DIVIDEND_W-2:0], fits};
  end

  assign low_bits     = quo_reg[DIVISOR_W-1:0];
  assign divisor_zero = (div_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_reg <= '0;
      rem_reg <= '0;
      div_reg <= '0;
    end else if (load) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      div_reg <= divisor;
    end else if (step) begin
      quo_reg <= quo_next;
      rem_reg <= rem_next;
    end
  end
endmodule

// File: rtl/kernel_stage0_udiv_19ns_5ns_14_seq.sv
// Sequential 19/5 unsigned divider with valid/ready handshakes, clock enable,
// quotient saturation and divide-by-zero reporting.
module kernel_stage0_udiv_19ns_5ns_14_seq
  import kernel_stage0_pkg::*;
#(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd19,
  parameter int unsigned din1_WIDTH = 32'd5,
  parameter int unsigned dout_WIDTH = 32'd14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic                  ovf
);
  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [QUOTIENT_W-1:0] dout_reg;
  logic [DIVISOR_W-1:0] rem_reg;
  logic                 dbz_reg, ovf_reg;
  logic                 load, step, capture, capture_zero;
  logic [DIVIDEND_W-1:0] quo_next;
  logic [DIVISOR_W-1:0] rem_next, low_bits;
  logic                 divisor_zero;

  kernel_stage0_udiv_19ns_5ns_14_seq_core u_core (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .dividend     (din0),
    .divisor      (din1),
    .quo_next     (quo_next),
    .rem_next     (rem_next),
    .low_bits     (low_bits),
    .divisor_zero (divisor_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    load         = 1'b0;
    step         = 1'b0;
    capture      = 1'b0;
    capture_zero = 1'b0;
    case (state_reg)
      IDLE: if (ce && in_valid) begin
        load       = 1'b1;
        state_next = BUSY;
      end
      BUSY: if (ce) begin
        if (divisor_zero) begin
          capture_zero = 1'b1;
          state_next   = DONE;
        end else begin
          step = 1'b1;
          if (cnt_reg == LAST_ITER) begin
            capture    = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: if (ce && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The last step's result is captured straight from the core's next values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      dout_reg <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      if (load)      cnt_reg <= '0;
      else if (step) cnt_reg <= cnt_reg + 1'b1;
      if (capture) begin
        ovf_reg  <= |quo_next[DIVIDEND_W-1:QUOTIENT_W];
        dout_reg <= (|quo_next[DIVIDEND_W-1:QUOTIENT_W]) ? SAT_QUO : quo_next[QUOTIENT_W-1:0];
        rem_reg  <= rem_next;
        dbz_reg  <= 1'b0;
      end else if (capture_zero) begin
        ovf_reg  <= 1'b0;
        dout_reg <= SAT_QUO;
        rem_reg  <= low_bits;
        dbz_reg  <= 1'b1;
      end
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign dout        = dout_reg;
  assign rem         = rem_reg;
  assign div_by_zero = dbz_reg;
  assign ovf         = ovf_reg;
endmodule
